// File: rtl/synth_pkg.sv
// synth_pkg: shared types for the synthesizer stream path.
// Sample/stream widths, sample type, sink FSM states.
package synth_pkg;

  localparam int SAMPLE_W = 24;
  localparam int STREAM_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } sink_state_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/stream_sample_sink_if.sv
// stream_sample_sink_if: Avalon-ST word channel
// from the mSGDMA playback path into the sink.
interface stream_sample_sink_if;
  import synth_pkg::*;

  logic [STREAM_W-1:0] asi_snk0_data;
  logic                asi_snk0_valid;
  logic                asi_snk0_ready;

  modport master (
    output asi_snk0_data,
    output asi_snk0_valid,
    input  asi_snk0_ready
  );

  modport slave (
    input  asi_snk0_data,
    input  asi_snk0_valid,
    output asi_snk0_ready
  );

endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous show-ahead FIFO with
// registered occupancy; storage is not reset.
module sample_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 24,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // pointers wrap naturally; level tracks net change
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/stream_sample_sink.sv
// stream_sample_sink: buffers Avalon-ST samples, paces them to the DAC.
// Optional: SAMPLE_SINK_ZERO_ON_UNDERRUN_EN drives silence while starved.
module stream_sample_sink
  import synth_pkg::*;
#(
  parameter  int DEPTH       = 16,
  parameter  int PREFILL     = 8,
  parameter  int CLK_FREQ    = 50_000_000,
  parameter  int SAMPLE_RATE = 96_000,
  localparam int LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  stream_sample_sink_if.slave  snk,
  output sample_t              o_sample,
  output logic                 o_sample_strobe,
  output logic [LVL_W-1:0]     o_level,
  output logic                 o_running,
  output logic [15:0]          o_underrun_cnt
);

  localparam int DIV   = CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic [7:0]          unused_hi;
  sink_state_t         state;

  assign unused_hi = snk.asi_snk0_data[STREAM_W-1:SAMPLE_W];

  assign tick = (tick_cnt == CNT_W'(DIV - 1));

  // no bypass: a pop on a full cycle does not open ready
  assign snk.asi_snk0_ready = n_rst & ~full;

  assign push = snk.asi_snk0_valid & snk.asi_snk0_ready;
  assign pop  = tick & (state == ST_RUN) & ~empty;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .din   (snk.asi_snk0_data[SAMPLE_W-1:0]),
    .dout  (fifo_dout),
    .level (o_level),
    .full  (full),
    .empty (empty)
  );

  // free-running sample-rate divider, active in every state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // playback FSM: prefill, then one pop per tick until starved
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= ST_FILL;
      o_running       <= 1'b0;
      o_sample        <= '0;
      o_sample_strobe <= 1'b0;
      o_underrun_cnt  <= '0;
    end else begin
      o_sample_strobe <= tick;
      unique case (state)
        ST_FILL: begin
`ifdef SAMPLE_SINK_ZERO_ON_UNDERRUN_EN
          if (tick) begin
            o_sample <= '0;
          end
`endif
          if (o_level >= LVL_W'(PREFILL)) begin
            state     <= ST_RUN;
            o_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tick) begin
            if (!empty) begin
              o_sample <= sample_t'(fifo_dout);
            end else begin
              state          <= ST_FILL;
              o_running      <= 1'b0;
              o_underrun_cnt <= sat_inc16(o_underrun_cnt);
`ifdef SAMPLE_SINK_ZERO_ON_UNDERRUN_EN
              o_sample       <= '0;
`endif
            end
          end
        end
        default: begin
          state     <= ST_FILL;
          o_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sample_sink.sv
// tb_stream_sample_sink: random-stimulus bench with queue reference model.
// Honors SAMPLE_SINK_ZERO_ON_UNDERRUN_EN for the starved-output value.
module tb_stream_sample_sink;
  import synth_pkg::*;

  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;
  localparam int DIV     = 50_000_000 / 96_000;

`ifdef SAMPLE_SINK_ZERO_ON_UNDERRUN_EN
  localparam logic [23:0] STARVED = 24'h000000;
`else
  localparam logic [23:0] STARVED = 24'h000008;
`endif

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  stream_sample_sink_if snk();

  sample_t     o_sample;
  logic        o_sample_strobe;
  logic [4:0]  o_level;
  logic        o_running;
  logic [15:0] o_underrun_cnt;

  stream_sample_sink #(
    .DEPTH       (DEPTH),
    .PREFILL     (PREFILL),
    .CLK_FREQ    (50_000_000),
    .SAMPLE_RATE (96_000)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .snk             (snk),
    .o_sample        (o_sample),
    .o_sample_strobe (o_sample_strobe),
    .o_level         (o_level),
    .o_running       (o_running),
    .o_underrun_cnt  (o_underrun_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference: time in cycles, FIFO as a queue
  int unsigned m_cnt = 0;
  logic [23:0] mq[$];
  int          m_lvl = 0;
  bit          m_run = 0;
  bit          m_stb = 0;
  logic [23:0] m_smp = '0;
  logic [15:0] m_unr = '0;
  logic        m_rdy;

  assign m_rdy = n_rst && (m_lvl < DEPTH);

  always @(posedge clk or negedge n_rst) begin
    bit tk;
    bit run0;
    int sz0;
    bit acc;
    if (!n_rst) begin
      m_cnt = 0;
      mq.delete();
      m_lvl = 0;
      m_run = 0;
      m_stb = 0;
      m_smp = '0;
      m_unr = '0;
    end else begin
      tk   = (m_cnt == DIV - 1);
      run0 = m_run;
      sz0  = mq.size();
      acc  = snk.asi_snk0_valid && (sz0 < DEPTH);
      m_cnt = (m_cnt + 1) % DIV;
      m_stb = tk;
      if (tk && run0) begin
        if (sz0 > 0) begin
          m_smp = mq.pop_front();
        end else begin
          if (m_unr != 16'hFFFF) m_unr = m_unr + 16'd1;
          m_run = 0;
`ifdef SAMPLE_SINK_ZERO_ON_UNDERRUN_EN
          m_smp = '0;
`endif
        end
      end
`ifdef SAMPLE_SINK_ZERO_ON_UNDERRUN_EN
      if (tk && !run0) m_smp = '0;
`endif
      if (!run0 && sz0 >= PREFILL) m_run = 1;
      if (acc) mq.push_back(snk.asi_snk0_data[23:0]);
      m_lvl = mq.size();
    end
  end

  logic [47:0] dut_v;
  logic [47:0] mdl_v;

  assign dut_v = {o_level, o_running, o_sample_strobe,
                  o_sample, o_underrun_cnt, snk.asi_snk0_ready};
  assign mdl_v = {5'(m_lvl), m_run, m_stb,
                  m_smp, m_unr, m_rdy};

  task automatic test_reset();
    snk.asi_snk0_valid = 1'b1;
    snk.asi_snk0_data  = $urandom();
    n_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_v !== 48'h0) begin
        miscompares++;
        $display("FAIL reset_state cyc %0d got %h exp %h", i, dut_v, 48'h0);
      end
    end
    snk.asi_snk0_valid = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (snk.asi_snk0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b exp 1", snk.asi_snk0_ready);
    end
    vectors++;
    if (dut_v !== mdl_v) begin
      miscompares++;
      $display("FAIL reset_release got %h exp %h", dut_v, mdl_v);
    end
  endtask

  task automatic test_prefill();
    int gap;
    for (int i = 1; i <= 7; i++) begin
      snk.asi_snk0_valid = 1'b1;
      snk.asi_snk0_data  = {8'($urandom()), 24'(i)};
      @(negedge clk);
      vectors++;
      if (dut_v !== mdl_v) begin
        miscompares++;
        $display("FAIL prefill_push %0d got %h exp %h", i, dut_v, mdl_v);
      end
    end
    snk.asi_snk0_valid = 1'b0;
    for (int c = 0; c < 2 * DIV + 10; c++) begin
      @(negedge clk);
      vectors++;
      if (dut_v !== mdl_v) begin
        miscompares++;
        $display("FAIL prefill_idle cyc %0d got %h exp %h", c, dut_v, mdl_v);
      end
    end
    vectors++;
    if (o_running !== 1'b0 || o_level !== 5'd7) begin
      miscompares++;
      $display("FAIL prefill_hold run %b lvl %0d exp run 0 lvl 7", o_running, o_level);
    end
    snk.asi_snk0_valid = 1'b1;
    snk.asi_snk0_data  = {8'($urandom()), 24'd8};
    @(negedge clk);
    snk.asi_snk0_valid = 1'b0;
    vectors++;
    if (o_level !== 5'd8 || o_running !== 1'b0) begin
      miscompares++;
      $display("FAIL prefill_eighth lvl %0d run %b exp lvl 8 run 0", o_level, o_running);
    end
    @(negedge clk);
    vectors++;
    if (o_running !== 1'b1) begin
      miscompares++;
      $display("FAIL prefill_running got %b exp 1", o_running);
    end
    for (int k = 1; k <= 3; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        vectors++;
        if (dut_v !== mdl_v) begin
          miscompares++;
          $display("FAIL prefill_play got %h exp %h", dut_v, mdl_v);
        end
      end while (!m_stb && gap < 2 * DIV);
      vectors++;
      if (o_sample !== 24'(k) || o_sample_strobe !== 1'b1) begin
        miscompares++;
        $display("FAIL prefill_pop %0d got %h stb %b exp %h stb 1", k, o_sample, o_sample_strobe, 24'(k));
      end
      if (k > 1) begin
        vectors++;
        if (gap != DIV) begin
          miscompares++;
          $display("FAIL strobe_period got %0d exp %0d", gap, DIV);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [20];
    int idx;
    int guard;
    bit acc;
    for (int i = 0; i < 20; i++) w[i] = $urandom();
    idx   = 0;
    guard = 0;
    while (idx < 20 && guard < 30 * DIV) begin
      snk.asi_snk0_valid = 1'b1;
      snk.asi_snk0_data  = w[idx];
      acc = m_rdy;
      if (m_lvl == DEPTH) begin
        vectors++;
        if (snk.asi_snk0_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_full_ready got %b exp 0", snk.asi_snk0_ready);
        end
      end
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_v !== mdl_v) begin
        miscompares++;
        $display("FAIL bp_cycle word %0d got %h exp %h", idx, dut_v, mdl_v);
      end
      if (acc) idx++;
    end
    snk.asi_snk0_valid = 1'b0;
    vectors++;
    if (idx != 20) begin
      miscompares++;
      $display("FAIL bp_accept_timeout got %0d exp 20", idx);
    end
    guard = 0;
    while (m_unr == 16'd0 && guard < 30 * DIV) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_v !== mdl_v) begin
        miscompares++;
        $display("FAIL bp_drain got %h exp %h", dut_v, mdl_v);
      end
    end
    vectors++;
    if (o_underrun_cnt !== 16'd1 || o_running !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_end unr %0d run %b exp unr 1 run 0", o_underrun_cnt, o_running);
    end
  endtask

  task automatic test_underrun();
    int guard;
    for (int i = 1; i <= 8; i++) begin
      snk.asi_snk0_valid = 1'b1;
      snk.asi_snk0_data  = {8'($urandom()), 24'(i)};
      @(negedge clk);
      vectors++;
      if (dut_v !== mdl_v) begin
        miscompares++;
        $display("FAIL ur_push %0d got %h exp %h", i, dut_v, mdl_v);
      end
    end
    snk.asi_snk0_valid = 1'b0;
    guard = 0;
    while (!m_run && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 1; k <= 9; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
        vectors++;
        if (dut_v !== mdl_v) begin
          miscompares++;
          $display("FAIL ur_cycle got %h exp %h", dut_v, mdl_v);
        end
      end while (!m_stb && guard < 2 * DIV);
      if (k <= 8) begin
        vectors++;
        if (o_sample !== 24'(k)) begin
          miscompares++;
          $display("FAIL ur_pop %0d got %h exp %h", k, o_sample, 24'(k));
        end
      end else begin
        vectors++;
        if (o_underrun_cnt !== 16'd2 || o_running !== 1'b0 || o_sample !== STARVED) begin
          miscompares++;
          $display("FAIL ur_event unr %0d run %b smp %h exp unr 2 run 0 smp %h",
                   o_underrun_cnt, o_running, o_sample, STARVED);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] w [8];
    logic [31:0] extra;
    int guard;
    w[0] = 32'hAB800000;
    for (int i = 1; i < 8; i++) w[i] = $urandom();
    for (int i = 0; i < 8; i++) begin
      snk.asi_snk0_valid = 1'b1;
      snk.asi_snk0_data  = w[i];
      @(negedge clk);
    end
    snk.asi_snk0_valid = 1'b0;
    guard = 0;
    while (!m_run && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 3; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
        vectors++;
        if (dut_v !== mdl_v) begin
          miscompares++;
          $display("FAIL sim_cycle got %h exp %h", dut_v, mdl_v);
        end
      end while (!m_stb && guard < 2 * DIV);
      if (k == 0) begin
        vectors++;
        if (o_sample !== 24'h800000 || $signed(o_sample) != -8388608) begin
          miscompares++;
          $display("FAIL sign_trunc got %h exp 800000", o_sample);
        end
      end
    end
    vectors++;
    if (o_level !== 5'd5) begin
      miscompares++;
      $display("FAIL sim_pre_level got %0d exp 5", o_level);
    end
    guard = 0;
    while (m_cnt != DIV - 1 && guard < 2 * DIV) begin
      @(negedge clk);
      guard++;
    end
    extra = $urandom();
    snk.asi_snk0_valid = 1'b1;
    snk.asi_snk0_data  = extra;
    @(negedge clk);
    snk.asi_snk0_valid = 1'b0;
    vectors++;
    if (o_level !== 5'd5 || o_sample !== w[3][23:0] || o_sample_strobe !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_pushpop lvl %0d smp %h stb %b exp lvl 5 smp %h stb 1",
               o_level, o_sample, o_sample_strobe, w[3][23:0]);
    end
    guard = 0;
    while (m_unr == 16'd2 && guard < 10 * DIV) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_v !== mdl_v) begin
        miscompares++;
        $display("FAIL sim_drain got %h exp %h", dut_v, mdl_v);
      end
    end
    vectors++;
    if (o_underrun_cnt !== 16'd3 || o_level !== 5'd0) begin
      miscompares++;
      $display("FAIL sim_end unr %0d lvl %0d exp unr 3 lvl 0", o_underrun_cnt, o_level);
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 3; i++) begin
      snk.asi_snk0_valid = 1'b1;
      snk.asi_snk0_data  = $urandom();
      @(negedge clk);
    end
    snk.asi_snk0_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    vectors++;
    if (dut_v !== 48'h0) begin
      miscompares++;
      $display("FAIL midreset got %h exp %h", dut_v, 48'h0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (dut_v !== mdl_v) begin
        miscompares++;
        $display("FAIL midreset_after got %h exp %h", dut_v, mdl_v);
      end
    end
  endtask

  initial begin
    snk.asi_snk0_valid = 1'b0;
    snk.asi_snk0_data  = '0;
    test_reset();
    test_prefill();
    test_back_to_back();
    test_underrun();
    test_simultaneous();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
